// File: rtl/gpu_video_pkg.sv
// Shared video definitions for the GPU display path: 640x480@60 timing defaults,
// pixel layout, scan-out lock states and the test-pattern bar colours.
package gpu_video_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int COLOR_W = 8;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pixel_t;

  typedef enum logic {
    SEEK   = 1'b0,
    LOCKED = 1'b1
  } scan_state_e;

  // White..black is a binary count where each channel follows one inverted index bit.
  function automatic pixel_t bar_color(input logic [2:0] idx);
    pixel_t p;
    p.r = {COLOR_W{~idx[1]}};
    p.g = {COLOR_W{~idx[2]}};
    p.b = {COLOR_W{~idx[0]}};
    return p;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters for the VGA scan-out with unregistered active/sync/frame strobes.
// With VGA_TEST_PATTERN_EN defined it also exports the colour-bar index.
module vga_timing_gen
  import gpu_video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output logic       active,
  output logic       hs_n,
  output logic       vs_n,
  output logic       frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [2:0] bar_idx
`endif
);

  localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW          = $clog2(LINE_LEN);
  localparam int VW          = $clog2(FRAME_LINES);

  localparam logic [HW-1:0] H_LAST     = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(FRAME_LINES - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active      = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hs_n        = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
  assign vs_n        = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_TEST_PATTERN_EN
  // Only meaningful inside the active region; blanking masks the rest.
  assign bar_idx = 3'(32'(h_cnt) / (H_ACTIVE / 8));
`endif

endmodule

// File: rtl/vga_scanout.sv
// VGA back end: locks the pixel stream to the raster and drives the ADV7123 pins.
// Optional colour-bar generator with input tp_sel when VGA_TEST_PATTERN_EN is defined.
module vga_scanout
  import gpu_video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3*COLOR_W-1:0] pix_data,
  input  logic                 pix_sof,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_blank_n,
  output logic                 vga_sync_n,
  output logic                 frame_start,
  output logic                 underflow
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic                 tp_sel
`endif
);

  logic active;
  logic hs_n;
  logic vs_n;
  logic origin;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_idx;
`endif

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .hs_n        (hs_n),
    .vs_n        (vs_n),
    .frame_start (origin)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .bar_idx     (bar_idx)
`endif
  );

  scan_state_e state;
  scan_state_e next_state;
  logic        err_frame;
  logic        next_err;
  logic        set_underflow;
  logic        ready_c;
  logic        seek_now;
  pixel_t      rgb_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEEK;
      err_frame <= 1'b0;
    end else begin
      state     <= next_state;
      err_frame <= next_err;
    end
  end

  // A spoiled frame drops back to SEEK at the origin and is judged by SEEK rules in that same cycle.
  always_comb begin
    next_state    = state;
    next_err      = err_frame;
    set_underflow = 1'b0;
    ready_c       = 1'b0;
    rgb_next      = '0;
    seek_now      = (state == SEEK) || (origin && err_frame);
    if (origin && err_frame) next_err = 1'b0;
    if (seek_now) begin
      next_state = SEEK;
      if (active) begin
        if (origin && pix_valid && pix_sof) begin
          next_state = LOCKED;
          ready_c    = 1'b1;
          rgb_next   = pixel_t'(pix_data);
        end else if (!pix_sof) begin
          ready_c = 1'b1;
        end
      end
    end else if (active && !err_frame) begin
      if (!pix_valid) begin
        next_err      = 1'b1;
        set_underflow = 1'b1;
      end else if (pix_sof && !origin) begin
        next_err = 1'b1;
      end else begin
        ready_c  = 1'b1;
        rgb_next = pixel_t'(pix_data);
      end
    end
`ifdef VGA_TEST_PATTERN_EN
    if (tp_sel) begin
      next_state    = SEEK;
      next_err      = 1'b0;
      set_underflow = 1'b0;
      ready_c       = 1'b1;
      rgb_next      = active ? bar_color(bar_idx) : '0;
    end
`endif
  end

  assign pix_ready  = ready_c & ~reset;
  assign vga_sync_n = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      vga_r       <= rgb_next.r;
      vga_g       <= rgb_next.g;
      vga_b       <= rgb_next.b;
      vga_hs      <= hs_n;
      vga_vs      <= vs_n;
      vga_blank_n <= active;
      frame_start <= origin;
      if (set_underflow) underflow <= 1'b1;
    end
  end

endmodule
